regfile_dump_ctrl: RTL and testbench

//  Sequencer for the processor's debug register-read port (inr -> out_value). After start, waits for HALT,

---
 rtl/regfile_dump_ctrl.sv | 135 +++++++++++++
 tb/tb_regfile_dump_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump_ctrl.sv
// Walks the processor debug read port (inr -> out_value) once HALT is seen and streams
// (addr, data) beats over valid/ready.
//   state     | meaning
//   IDLE      | waiting for start
//   WAIT_HALT | waiting for halted, bounded by HaltTimeout cycles
//   SETTLE    | inr applied, waiting ReadLatency cycles for out_value
//   PRESENT   | beat held on dump_* until accepted
//   DONE      | one-cycle done pulse
module regfile_dump_ctrl #(
  parameter int RegAddrBits = 3,
  parameter int DataWidth   = 16,
  parameter int TotalReg    = 8,
  parameter int ReadLatency = 1,
  parameter int HaltTimeout = 255,
  parameter int TimeoutBits = 8
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   start,
  input  logic                   halted,
  output logic [RegAddrBits-1:0] inr,
  input  logic [DataWidth-1:0]   out_value,
  output logic                   dump_valid,
  input  logic                   dump_ready,
  output logic [RegAddrBits-1:0] dump_addr,
  output logic [DataWidth-1:0]   dump_data,
  output logic                   dump_last,
  output logic                   busy,
  output logic                   done,
  output logic                   timeout
);

  localparam int SettleBits = $clog2(ReadLatency + 1);

  typedef enum logic [2:0] {IDLE, WAIT_HALT, SETTLE, PRESENT, DONE} state_t;

  state_t                 state, state_nx;
  logic [TimeoutBits-1:0] timer, timer_nx;
  logic [SettleBits-1:0]  settle, settle_nx;
  logic [RegAddrBits-1:0] inr_nx, addr_nx;
  logic [DataWidth-1:0]   data_nx;
  logic                   valid_nx, last_nx, timeout_nx, busy_nx, done_nx;

  always_comb begin
    state_nx   = state;
    timer_nx   = timer;
    settle_nx  = settle;
    inr_nx     = inr;
    addr_nx    = dump_addr;
    data_nx    = dump_data;
    valid_nx   = dump_valid;
    last_nx    = dump_last;
    timeout_nx = timeout;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx   = WAIT_HALT;
          timeout_nx = 1'b0;
          timer_nx   = '0;
          inr_nx     = '0;
        end
      end
      WAIT_HALT: begin
        if (halted) begin
          state_nx  = SETTLE;
          settle_nx = SettleBits'(ReadLatency);
        end else if (timer == TimeoutBits'(HaltTimeout - 1)) begin
          state_nx   = IDLE;
          timeout_nx = 1'b1;
        end else begin
          timer_nx = timer + TimeoutBits'(1);
        end
      end
      SETTLE: begin
        settle_nx = settle - SettleBits'(1);
        // count==1 marks the last settle cycle, so out_value is valid at this edge
        if (settle == SettleBits'(1)) begin
          state_nx = PRESENT;
          data_nx  = out_value;
          addr_nx  = inr;
          last_nx  = (inr == RegAddrBits'(TotalReg - 1));
          valid_nx = 1'b1;
        end
      end
      PRESENT: begin
        if (dump_ready) begin
          valid_nx = 1'b0;
          if (dump_last) begin
            state_nx = DONE;
          end else begin
            state_nx  = SETTLE;
            inr_nx    = inr + RegAddrBits'(1);
            settle_nx = SettleBits'(ReadLatency);
          end
        end
      end
      DONE: begin
        state_nx = IDLE;
        inr_nx   = '0;
      end
      default: state_nx = IDLE;
    endcase
    busy_nx = (state_nx != IDLE);
    done_nx = (state_nx == DONE);
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state      <= IDLE;
      timer      <= '0;
      settle     <= '0;
      inr        <= '0;
      dump_addr  <= '0;
      dump_data  <= '0;
      dump_valid <= 1'b0;
      dump_last  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state      <= state_nx;
      timer      <= timer_nx;
      settle     <= settle_nx;
      inr        <= inr_nx;
      dump_addr  <= addr_nx;
      dump_data  <= data_nx;
      dump_valid <= valid_nx;
      dump_last  <= last_nx;
      busy       <= busy_nx;
      done       <= done_nx;
      timeout    <= timeout_nx;
    end
  end

endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// Scoreboard bench for regfile_dump_ctrl: one instance with ReadLatency=1, one with ReadLatency=3,
// each fed by a processor model holding the result of ADDI/ADDI/OR/HALT.
module tb_regfile_dump_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start1 = 1'b0, start3 = 1'b0, halted = 1'b0, ready = 1'b0;
  logic sel = 1'b0;

  logic [2:0]  inr1, a1, inr3, a3;
  logic [15:0] ov1, d1, ov3, d3, p0;
  logic        v1, l1, b1, dn1, to1;
  logic        v3, l3, b3, dn3, to3;

  always #5 clk = ~clk;

  // register file after ADDI $3,$0,0x000A; ADDI $4,$0,0x0015; OR $5,$3,$4; HALT
  function automatic logic [15:0] regval(input logic [2:0] a);
    case (a)
      3'd3:    return 16'h000A;
      3'd4:    return 16'h0015;
      3'd5:    return 16'h001F;
      default: return 16'h0000;
    endcase
  endfunction

  // latency 1: combinational read; latency 3: two register stages after inr
  assign ov1 = regval(inr1);
  always @(posedge clk) begin
    p0  <= regval(inr3);
    ov3 <= p0;
  end

  regfile_dump_ctrl #(.ReadLatency(1)) dut1 (
    .CLK(clk), .RST(rst), .start(start1), .halted(halted), .inr(inr1), .out_value(ov1),
    .dump_valid(v1), .dump_ready(ready), .dump_addr(a1), .dump_data(d1), .dump_last(l1),
    .busy(b1), .done(dn1), .timeout(to1));

  regfile_dump_ctrl #(.ReadLatency(3)) dut3 (
    .CLK(clk), .RST(rst), .start(start3), .halted(halted), .inr(inr3), .out_value(ov3),
    .dump_valid(v3), .dump_ready(ready), .dump_addr(a3), .dump_data(d3), .dump_last(l3),
    .busy(b3), .done(dn3), .timeout(to3));

  wire        v   = sel ? v3 : v1;
  wire        l   = sel ? l3 : l1;
  wire        b   = sel ? b3 : b1;
  wire        dn  = sel ? dn3 : dn1;
  wire        to  = sel ? to3 : to1;
  wire [2:0]  a   = sel ? a3 : a1;
  wire [2:0]  inr = sel ? inr3 : inr1;
  wire [15:0] d   = sel ? d3 : d1;

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic [2:0]  a;
    logic [15:0] d;
    logic        l;
  } beat_t;

  beat_t q1[$];
  beat_t q3[$];
  beat_t e1, e3;
  int beats1 = 0, beats3 = 0, dones1 = 0, dones3 = 0;
  int base_beats, base_dones;

  logic [15:0] exp_data [8] = '{16'h0000, 16'h0000, 16'h0000, 16'h000A,
                                16'h0015, 16'h001F, 16'h0000, 16'h0000};

  always @(negedge clk) begin
    if (rst && v1 && ready) begin
      beats1++;
      if (q1.size() == 0) check("unexpected beat dut1", 1, 0);
      else begin
        e1 = q1.pop_front();
        check("beat addr dut1", a1, e1.a);
        check("beat data dut1", d1, e1.d);
        check("beat last dut1", l1, e1.l);
      end
    end
    if (rst && dn1) dones1++;
  end

  always @(negedge clk) begin
    if (rst && v3 && ready) begin
      beats3++;
      if (q3.size() == 0) check("unexpected beat dut3", 1, 0);
      else begin
        e3 = q3.pop_front();
        check("beat addr dut3", a3, e3.a);
        check("beat data dut3", d3, e3.d);
        check("beat last dut3", l3, e3.l);
      end
    end
    if (rst && dn3) dones3++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    if (sel) start3 = 1'b1;
    else start1 = 1'b1;
    step();
    start1 = 1'b0;
    start3 = 1'b0;
  endtask

  task automatic start_dump();
    beat_t bt;
    for (int i = 0; i < 8; i++) begin
      bt.a = 3'(i);
      bt.d = exp_data[i];
      bt.l = (i == 7);
      if (sel) q3.push_back(bt);
      else q1.push_back(bt);
    end
    base_beats = sel ? beats3 : beats1;
    base_dones = sel ? dones3 : dones1;
    pulse_start();
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!v && n < 400) begin
      step();
      n++;
    end
  endtask

  task automatic wait_addr(input logic [2:0] want);
    int n = 0;
    while (!(v && a == want) && n < 200) begin
      step();
      n++;
    end
    check("reach beat addr", {v, a}, {1'b1, want});
  endtask

  task automatic run_to_done();
    int n = 0;
    while (!(v && l) && n < 200) begin
      step();
      n++;
    end
    check("reach last beat", {v, l}, 2'b11);
    step();
    check("done pulse", {dn, v, b}, 3'b101);
    step();
    check("idle after done", {dn, b, inr}, 0);
    check("beat count", (sel ? beats3 : beats1) - base_beats, 8);
    check("done count", (sel ? dones3 : dones1) - base_dones, 1);
    check("scoreboard drained", sel ? q3.size() : q1.size(), 0);
  endtask

  initial begin
    int n;
    // 1: reset held with start asserted
    rst = 1'b0; start1 = 1'b1; start3 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("reset outputs dut1", {inr1, v1, a1, d1, l1, b1, dn1, to1}, 0);
      check("reset outputs dut3", {inr3, v3, a3, d3, l3, b3, dn3, to3}, 0);
    end
    rst = 1'b1; start1 = 1'b0; start3 = 1'b0;
    step();
    check("idle after reset", {b1, v1, b3}, 0);

    // 2: full dump, ready always high
    halted = 1'b1; ready = 1'b1; sel = 1'b0;
    start_dump();
    wait_valid(n);
    check("first valid latency rl1", n, 2);
    check("first beat addr", {a, d}, 0);
    run_to_done();

    // 3: consumer stalls on addr 3
    start_dump();
    wait_addr(3'd3);
    ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall hold", {v, a, d, inr}, {1'b1, 3'd3, 16'h000A, 3'd3});
    end
    ready = 1'b1;
    step();
    check("valid drops after handshake", v, 0);
    step();
    check("beat4 after ready", {v, a, d}, {1'b1, 3'd4, 16'h0015});
    run_to_done();

    // 4: halt never arrives
    halted = 1'b0;
    pulse_start();
    begin
      logic ok = 1'b1;
      if (!b || v) ok = 1'b0;
      for (int i = 0; i < 254; i++) begin
        step();
        if (!b || v) ok = 1'b0;
      end
      check("busy through wait_halt", ok, 1);
    end
    step();
    check("timeout abort", {to, b, v}, 3'b100);
    step();
    step();
    check("timeout sticky", {to, b}, 2'b10);
    halted = 1'b1;
    start_dump();
    check("start clears timeout", {to, b}, 2'b01);
    run_to_done();

    // 5: extra start mid-dump ignored, then reset mid-dump
    start_dump();
    wait_addr(3'd2);
    pulse_start();
    run_to_done();
    start_dump();
    wait_addr(3'd5);
    rst = 1'b0;
    step();
    check("mid-dump reset", {inr1, v1, a1, d1, l1, b1, dn1, to1}, 0);
    rst = 1'b1;
    q1.delete();
    start_dump();
    wait_valid(n);
    check("restart latency", n, 2);
    check("restart addr", {v, a}, {1'b1, 3'd0});
    run_to_done();

    // 6: late halt, then ReadLatency=3 instance
    halted = 1'b0;
    start_dump();
    repeat (40) step();
    check("waiting for halt", {b, v, to}, 3'b100);
    halted = 1'b1;
    run_to_done();
    check("no timeout after late halt", to, 0);

    sel = 1'b1;
    start_dump();
    wait_valid(n);
    check("first valid latency rl3", n, 4);
    run_to_done();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
